data_bus_sync: RTL and testbench

- Multi-flop (MCP-style) bus synchronizer: brings a multi-bit bus from a foreign clock domain into the dest_clk domain.
- Only the single-bit qualifier bus_enable passes through an N-stage flop synchronizer.
- The rising edge of the synchronized enable is converted to a one-cycle pulse. That pulse loads unsync_bus into a destination register and is also output as enable_pulse.
- Sits at every clock-domain crossing that carries data plus a valid/enable from a slower or asynchronous source.

---
 rtl/data_bus_sync_pkg.sv | 9 +
 rtl/data_bus_sync_bit_sync.sv | 33 +++
 rtl/data_bus_sync.sv | 52 +++++
 tb/tb_data_bus_sync.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/data_bus_sync_pkg.sv
// Shared defaults for the clock-domain-crossing blocks.
// Other synchronizers can import these so that one edit changes every default.
package data_bus_sync_pkg;

  localparam int BUS_WIDTH_DEF  = 8;
  localparam int NUM_STAGES_DEF = 2;
  localparam int NUM_STAGES_MIN = 2;

endpackage

// File: rtl/data_bus_sync_bit_sync.sv
// Single-bit multi-flop synchronizer with asynchronous active-high reset.
// Reusable wherever a level signal crosses into the local clock domain.
module bit_sync
  import data_bus_sync_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  generate
    if (NUM_STAGES < NUM_STAGES_MIN) begin : g_bad_stages
      $error("bit_sync: NUM_STAGES must be at least 2");
    end
  endgenerate

  logic [NUM_STAGES-1:0] r_sync;

  // Stage 0 is the only flop allowed to go metastable; later stages give it time to settle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[NUM_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[NUM_STAGES-1];

endmodule

// File: rtl/data_bus_sync.sv
// Multi-cycle-path bus synchronizer: only bus_enable is synchronized; its rising
// edge loads the (by then stable) foreign bus and is reported as enable_pulse.
module data_bus_sync
  import data_bus_sync_pkg::*;
#(
  parameter int BUS_WIDTH  = BUS_WIDTH_DEF,
  parameter int NUM_STAGES = NUM_STAGES_DEF
) (
  input  logic                 dest_clk,
  input  logic                 dest_rst,
  input  logic                 bus_enable,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse
);

  logic                 w_sync_en;
  logic                 w_pulse;
  logic                 r_pg;
  logic [BUS_WIDTH-1:0] r_sync_bus;
  logic                 r_enable_pulse;

  bit_sync #(
    .NUM_STAGES(NUM_STAGES)
  ) u_en_sync (
    .i_clk(dest_clk),
    .i_rst(dest_rst),
    .i_d  (bus_enable),
    .o_q  (w_sync_en)
  );

  // One pulse per rising edge of the synchronized enable, however long it stays high.
  assign w_pulse = w_sync_en & ~r_pg;

  always_ff @(posedge dest_clk or posedge dest_rst) begin
    if (dest_rst) begin
      r_pg           <= 1'b0;
      r_sync_bus     <= '0;
      r_enable_pulse <= 1'b0;
    end else begin
      r_pg           <= w_sync_en;
      r_enable_pulse <= w_pulse;
      if (w_pulse) begin
        r_sync_bus <= unsync_bus;
      end
    end
  end

  assign sync_bus     = r_sync_bus;
  assign enable_pulse = r_enable_pulse;

endmodule

// File: tb/tb_data_bus_sync.sv
// Directed bench for data_bus_sync: default instance plus two NUM_STAGES=3
// instances (16-bit and 1-bit buses) for the latency sweep.
module tb_data_bus_sync;

  logic        dest_clk;
  logic        dest_rst;
  logic        en_a;
  logic [7:0]  bus_a;
  logic [7:0]  sync_a;
  logic        pulse_a;
  logic        en_b;
  logic [15:0] bus_b;
  logic [15:0] sync_b;
  logic        pulse_b;
  logic        en_c;
  logic [0:0]  bus_c;
  logic [0:0]  sync_c;
  logic        pulse_c;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_count;

  data_bus_sync u_dut_a (
    .dest_clk    (dest_clk),
    .dest_rst    (dest_rst),
    .bus_enable  (en_a),
    .unsync_bus  (bus_a),
    .sync_bus    (sync_a),
    .enable_pulse(pulse_a)
  );

  data_bus_sync #(.BUS_WIDTH(16), .NUM_STAGES(3)) u_dut_b (
    .dest_clk    (dest_clk),
    .dest_rst    (dest_rst),
    .bus_enable  (en_b),
    .unsync_bus  (bus_b),
    .sync_bus    (sync_b),
    .enable_pulse(pulse_b)
  );

  data_bus_sync #(.BUS_WIDTH(1), .NUM_STAGES(3)) u_dut_c (
    .dest_clk    (dest_clk),
    .dest_rst    (dest_rst),
    .bus_enable  (en_c),
    .unsync_bus  (bus_c),
    .sync_bus    (sync_c),
    .enable_pulse(pulse_c)
  );

  initial dest_clk = 1'b0;
  always #5 dest_clk = ~dest_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Advance n posedges and land 2 time units after the last one (mid-cycle).
  task automatic step(input int n);
    repeat (n) @(posedge dest_clk);
    #2;
  endtask

  initial begin
    dest_rst = 1'b1;
    en_a = 1'b1; bus_a = 8'hFF;
    en_b = 1'b0; bus_b = 16'h0000;
    en_c = 1'b0; bus_c = 1'b0;
    #1;
    check("rst_bus_t0", 32'(sync_a), 32'h00);
    check("rst_pulse_t0", 32'(pulse_a), 32'h0);
    step(3);
    check("rst_bus_held", 32'(sync_a), 32'h00);
    check("rst_pulse_held", 32'(pulse_a), 32'h0);
    check("rst_bus_b", 32'(sync_b), 32'h0000);

    en_a = 1'b0; bus_a = 8'h00; dest_rst = 1'b0;
    step(3);

    // Latency: driven mid-cycle, sampled at the next edge, loaded on the 3rd edge.
    bus_a = 8'hAA; en_a = 1'b1;
    step(1);
    check("lat_pulse_e1", 32'(pulse_a), 32'h0);
    step(1);
    check("lat_pulse_e2", 32'(pulse_a), 32'h0);
    check("lat_bus_e2", 32'(sync_a), 32'h00);
    step(1);
    check("lat_pulse_e3", 32'(pulse_a), 32'h1);
    check("lat_bus_e3", 32'(sync_a), 32'hAA);
    step(1);
    check("lat_pulse_e4", 32'(pulse_a), 32'h0);
    check("lat_bus_e4", 32'(sync_a), 32'hAA);

    // Level enable: no further pulses, bus changes ignored.
    bus_a = 8'h55;
    pulse_count = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      pulse_count += int'(pulse_a);
    end
    check("level_extra_pulses", 32'(pulse_count), 32'd0);
    check("level_bus_hold", 32'(sync_a), 32'hAA);

    // Re-arm after a low period.
    en_a = 1'b0;
    step(4);
    bus_a = 8'h3C; en_a = 1'b1;
    step(2);
    check("rearm_pulse_e2", 32'(pulse_a), 32'h0);
    check("rearm_bus_e2", 32'(sync_a), 32'hAA);
    step(1);
    check("rearm_pulse_e3", 32'(pulse_a), 32'h1);
    check("rearm_bus_e3", 32'(sync_a), 32'h3C);
    step(1);
    check("rearm_pulse_e4", 32'(pulse_a), 32'h0);

    // Reset mid-propagation.
    en_a = 1'b0;
    step(4);
    bus_a = 8'h81; en_a = 1'b1;
    step(1);
    dest_rst = 1'b1;
    #1;
    check("midrst_bus_now", 32'(sync_a), 32'h00);
    check("midrst_pulse_now", 32'(pulse_a), 32'h0);
    step(2);
    check("midrst_pulse_held", 32'(pulse_a), 32'h0);
    dest_rst = 1'b0;
    step(2);
    check("midrst_pulse_e2", 32'(pulse_a), 32'h0);
    check("midrst_bus_e2", 32'(sync_a), 32'h00);
    step(1);
    check("midrst_pulse_e3", 32'(pulse_a), 32'h1);
    check("midrst_bus_e3", 32'(sync_a), 32'h81);
    step(1);
    check("midrst_pulse_e4", 32'(pulse_a), 32'h0);

    // NUM_STAGES=3 sweep: 4 edges from drive.
    bus_b = 16'hBEEF; en_b = 1'b1;
    bus_c = 1'b1;     en_c = 1'b1;
    step(3);
    check("sweep16_pulse_e3", 32'(pulse_b), 32'h0);
    check("sweep16_bus_e3", 32'(sync_b), 32'h0000);
    check("sweep1_pulse_e3", 32'(pulse_c), 32'h0);
    check("sweep1_bus_e3", 32'(sync_c), 32'h0);
    step(1);
    check("sweep16_pulse_e4", 32'(pulse_b), 32'h1);
    check("sweep16_bus_e4", 32'(sync_b), 32'hBEEF);
    check("sweep1_pulse_e4", 32'(pulse_c), 32'h1);
    check("sweep1_bus_e4", 32'(sync_c), 32'h1);
    step(1);
    check("sweep16_pulse_e5", 32'(pulse_b), 32'h0);
    check("sweep1_pulse_e5", 32'(pulse_c), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
